camera_power_seq: RTL and testbench

Parametrised power sequencer for up to NUM_CAM image sensors sharing one power-down line. It drives power-up (PWDN release, staggered per-camera reset release, SCCB-init enable) and a matching orderly power-down. A restart request re-runs the full cycle without a global reset. It sits between the board reset logic and the SCCB configuration masters; `initial_en` gates register loading.

---
 rtl/camera_power_seq_pkg.sv | 31 +++
 rtl/seq_timer.sv | 27 ++
 rtl/camera_power_seq.sv | 164 ++++++++++++++++
 tb/tb_camera_power_seq.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/camera_power_seq_pkg.sv
// Shared state encodings and default 50 MHz timing constants for the camera
// power sequencer and the SCCB init logic that follows it.
package camera_power_seq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_OFF       = 3'd0,
        ST_PWR_WAIT  = 3'd1,
        ST_RST_WAIT  = 3'd2,
        ST_STAGGER   = 3'd3,
        ST_INIT_WAIT = 3'd4,
        ST_READY     = 3'd5,
        ST_SHUTDOWN  = 3'd6,
        ST_UNUSED    = 3'd7
    } seq_state_e;

    localparam int DEF_NUM_CAM = 2;
    localparam int DEF_T_PWR   = 262144;
    localparam int DEF_T_RST   = 65536;
    localparam int DEF_T_STAG  = 1;
    localparam int DEF_T_INIT  = 1048576;
    localparam int DEF_T_SHDN  = 1024;
    localparam int DEF_CNT_W   = 21;

    // A duration T loads T-1, so T may be at most 2^w.
    function automatic logic t_fits(input int t, input int w);
        return (t >= 1) && (longint'(t) <= (longint'(1) << w));
    endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter that parks at zero; zero_o flags the final cycle of
// a timed interval.
module seq_timer #(
    parameter int CNT_W = 21
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] value_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= value_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/camera_power_seq.sv
// Power-up / power-down sequencer for up to eight image sensors sharing one
// PWDN line, with staggered per-camera reset release.
module camera_power_seq
    import camera_power_seq_pkg::*;
#(
    parameter int NUM_CAM = DEF_NUM_CAM,
    parameter int T_PWR   = DEF_T_PWR,
    parameter int T_RST   = DEF_T_RST,
    parameter int T_STAG  = DEF_T_STAG,
    parameter int T_INIT  = DEF_T_INIT,
    parameter int T_SHDN  = DEF_T_SHDN,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               clk_50M,
    input  logic               reset,
    input  logic               enable,
    input  logic               restart,
    output logic               camera_pwnd,
    output logic [NUM_CAM-1:0] camera_rstn,
    output logic               initial_en,
    output logic [STATE_W-1:0] seq_state,
    output logic               busy
);

    if (NUM_CAM < 1 || NUM_CAM > 8) begin : g_bad_num_cam
        $error("camera_power_seq: NUM_CAM must be 1..8");
    end
    if (!t_fits(T_PWR, CNT_W) || !t_fits(T_RST, CNT_W) || !t_fits(T_STAG, CNT_W) ||
        !t_fits(T_INIT, CNT_W) || !t_fits(T_SHDN, CNT_W)) begin : g_bad_timing
        $error("camera_power_seq: every T_* must be in 1..2^CNT_W");
    end

    seq_state_e         state_q, state_d;
    logic               pwnd_q, pwnd_d;
    logic [NUM_CAM-1:0] rstn_q, rstn_d;
    logic               init_en_q, init_en_d;
    logic               busy_q, busy_d;
    logic [2:0]         idx_q, idx_d;
    logic               tmr_load;
    logic [CNT_W-1:0]   tmr_value;
    logic               tmr_zero;
    logic [NUM_CAM-1:0] rel_sel;

    seq_timer #(.CNT_W(CNT_W)) u_timer (
        .clk     (clk_50M),
        .srst    (reset),
        .load_i  (tmr_load),
        .value_i (tmr_value),
        .zero_o  (tmr_zero)
    );

    for (genvar gi = 0; gi < NUM_CAM; gi++) begin : g_rel_sel
        assign rel_sel[gi] = (idx_q == 3'(gi));
    end

    always_comb begin
        state_d   = state_q;
        pwnd_d    = pwnd_q;
        rstn_d    = rstn_q;
        init_en_d = init_en_q;
        idx_d     = idx_q;
        tmr_load  = 1'b0;
        tmr_value = '0;
        case (state_q)
            ST_OFF: begin
                pwnd_d    = 1'b1;
                rstn_d    = '0;
                init_en_d = 1'b0;
                idx_d     = '0;
                if (enable) begin
                    state_d   = ST_PWR_WAIT;
                    tmr_load  = 1'b1;
                    tmr_value = CNT_W'(T_PWR - 1);
                end
            end
            ST_PWR_WAIT: begin
                if (!enable) begin
                    state_d = ST_OFF;
                end else if (tmr_zero) begin
                    state_d   = ST_RST_WAIT;
                    pwnd_d    = 1'b0;
                    tmr_load  = 1'b1;
                    tmr_value = CNT_W'(T_RST - 1);
                end
            end
            ST_RST_WAIT, ST_STAGGER, ST_INIT_WAIT: begin
                if (!enable) begin
                    state_d   = ST_SHUTDOWN;
                    rstn_d    = '0;
                    init_en_d = 1'b0;
                    idx_d     = '0;
                    tmr_load  = 1'b1;
                    tmr_value = CNT_W'(T_SHDN - 1);
                end else if (tmr_zero) begin
                    if (state_q == ST_INIT_WAIT) begin
                        state_d   = ST_READY;
                        init_en_d = 1'b1;
                    end else if (idx_q == 3'(NUM_CAM - 1)) begin
                        // The last release edge doubles as the INIT_WAIT entry edge.
                        state_d   = ST_INIT_WAIT;
                        rstn_d    = rstn_q | rel_sel;
                        tmr_load  = 1'b1;
                        tmr_value = CNT_W'(T_INIT - 1);
                    end else begin
                        state_d   = ST_STAGGER;
                        rstn_d    = rstn_q | rel_sel;
                        idx_d     = idx_q + 3'd1;
                        tmr_load  = 1'b1;
                        tmr_value = CNT_W'(T_STAG - 1);
                    end
                end
            end
            ST_READY: begin
                if (!enable || restart) begin
                    state_d   = ST_SHUTDOWN;
                    rstn_d    = '0;
                    init_en_d = 1'b0;
                    idx_d     = '0;
                    tmr_load  = 1'b1;
                    tmr_value = CNT_W'(T_SHDN - 1);
                end
            end
            ST_SHUTDOWN: begin
                if (tmr_zero) begin
                    state_d = ST_OFF;
                    pwnd_d  = 1'b1;
                end
            end
            default: begin
                state_d   = ST_OFF;
                pwnd_d    = 1'b1;
                rstn_d    = '0;
                init_en_d = 1'b0;
                idx_d     = '0;
            end
        endcase
        busy_d = !(state_d == ST_OFF || state_d == ST_READY);
    end

    always_ff @(posedge clk_50M) begin
        if (reset) begin
            state_q   <= ST_OFF;
            pwnd_q    <= 1'b1;
            rstn_q    <= '0;
            init_en_q <= 1'b0;
            busy_q    <= 1'b0;
            idx_q     <= '0;
        end else begin
            state_q   <= state_d;
            pwnd_q    <= pwnd_d;
            rstn_q    <= rstn_d;
            init_en_q <= init_en_d;
            busy_q    <= busy_d;
            idx_q     <= idx_d;
        end
    end

    assign camera_pwnd = pwnd_q;
    assign camera_rstn = rstn_q;
    assign initial_en  = init_en_q;
    assign seq_state   = state_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_camera_power_seq.sv
// Directed test-plan scenarios followed by random enable/restart/reset traffic,
// all checked against a timeline model of the power sequence.
module tb_camera_power_seq;

    localparam int NUM_CAM = 2;
    localparam int T_PWR   = 8;
    localparam int T_RST   = 4;
    localparam int T_STAG  = 3;
    localparam int T_INIT  = 5;
    localparam int T_SHDN  = 2;

    logic               clk_50M = 1'b0;
    logic               reset   = 1'b1;
    logic               enable  = 1'b0;
    logic               restart = 1'b0;
    logic               camera_pwnd;
    logic [NUM_CAM-1:0] camera_rstn;
    logic               initial_en;
    logic [2:0]         seq_state;
    logic               busy;

    int vectors     = 0;
    int miscompares = 0;

    // Timeline model: mode 0 = off, 1 = powering up since k_edge, 2 = shutting down since m_edge.
    int                 mcyc   = 0;
    int                 mmode  = 0;
    int                 k_edge = 0;
    int                 m_edge = 0;
    logic               exp_pwnd  = 1'b1;
    logic [NUM_CAM-1:0] exp_rstn  = '0;
    logic               exp_ie    = 1'b0;
    logic [2:0]         exp_state = 3'd0;
    logic               exp_busy  = 1'b0;

    camera_power_seq #(
        .NUM_CAM (NUM_CAM),
        .T_PWR   (T_PWR),
        .T_RST   (T_RST),
        .T_STAG  (T_STAG),
        .T_INIT  (T_INIT),
        .T_SHDN  (T_SHDN),
        .CNT_W   (4)
    ) dut (
        .clk_50M     (clk_50M),
        .reset       (reset),
        .enable      (enable),
        .restart     (restart),
        .camera_pwnd (camera_pwnd),
        .camera_rstn (camera_rstn),
        .initial_en  (initial_en),
        .seq_state   (seq_state),
        .busy        (busy)
    );

    always #5 clk_50M = ~clk_50M;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, got, exp, mcyc);
        end
    endtask

    function automatic logic [2:0] up_phase(input int e);
        if (e < T_PWR)                                              return 3'd1;
        if (e < T_PWR + T_RST)                                      return 3'd2;
        if (e < T_PWR + T_RST + (NUM_CAM - 1) * T_STAG)             return 3'd3;
        if (e < T_PWR + T_RST + (NUM_CAM - 1) * T_STAG + T_INIT)    return 3'd4;
        return 3'd5;
    endfunction

    task automatic model_edge(input logic r, input logic en, input logic rs);
        logic [2:0] prev;
        int e;
        prev = exp_state;
        mcyc++;
        if (r) begin
            mmode = 0;
        end else begin
            case (mmode)
                0: if (en) begin mmode = 1; k_edge = mcyc; end
                1: begin
                    if (prev == 3'd1 && !en) mmode = 0;
                    else if (!en || (prev == 3'd5 && rs)) begin mmode = 2; m_edge = mcyc; end
                end
                default: if (mcyc - m_edge >= T_SHDN) mmode = 0;
            endcase
        end
        case (mmode)
            0: begin
                exp_pwnd = 1'b1; exp_rstn = '0; exp_ie = 1'b0; exp_state = 3'd0; exp_busy = 1'b0;
            end
            1: begin
                e = mcyc - k_edge;
                exp_pwnd  = (e < T_PWR);
                for (int i = 0; i < NUM_CAM; i++)
                    exp_rstn[i] = (e >= T_PWR + T_RST + i * T_STAG);
                exp_state = up_phase(e);
                exp_ie    = (exp_state == 3'd5);
                exp_busy  = (exp_state != 3'd5);
            end
            default: begin
                exp_pwnd = 1'b0; exp_rstn = '0; exp_ie = 1'b0; exp_state = 3'd6; exp_busy = 1'b1;
            end
        endcase
    endtask

    task automatic tick(input logic r, input logic en, input logic rs);
        @(negedge clk_50M);
        reset   = r;
        enable  = en;
        restart = rs;
        @(posedge clk_50M);
        model_edge(r, en, rs);
        #1;
        chk("pwnd",  32'(camera_pwnd), 32'(exp_pwnd));
        chk("rstn",  32'(camera_rstn), 32'(exp_rstn));
        chk("ie",    32'(initial_en),  32'(exp_ie));
        chk("state", 32'(seq_state),   32'(exp_state));
        chk("busy",  32'(busy),        32'(exp_busy));
    endtask

    task automatic do_reset();
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        logic en_r;

        // Reset state and power-up, then plain shutdown at edge 30.
        do_reset();
        chk("rst_pwnd", 32'(camera_pwnd), 32'd1);
        chk("rst_state", 32'(seq_state), 32'd0);
        for (int t = 0; t <= 32; t++) begin
            tick(1'b0, (t < 30), 1'b0);
            if (t == 7)  chk("pu_pwnd_e7",  32'(camera_pwnd), 32'd1);
            if (t == 8)  chk("pu_pwnd_e8",  32'(camera_pwnd), 32'd0);
            if (t == 11) chk("pu_rstn_e11", 32'(camera_rstn), 32'b00);
            if (t == 12) chk("pu_rstn_e12", 32'(camera_rstn), 32'b01);
            if (t == 14) chk("pu_rstn_e14", 32'(camera_rstn), 32'b01);
            if (t == 15) chk("pu_rstn_e15", 32'(camera_rstn), 32'b11);
            if (t == 19) chk("pu_ie_e19",   32'(initial_en),  32'd0);
            if (t == 19) chk("pu_busy_e19", 32'(busy),        32'd1);
            if (t == 20) chk("pu_ie_e20",   32'(initial_en),  32'd1);
            if (t == 20) chk("pu_busy_e20", 32'(busy),        32'd0);
            if (t == 30) chk("sd_ie_e30",   32'(initial_en),  32'd0);
            if (t == 30) chk("sd_rstn_e30", 32'(camera_rstn), 32'b00);
            if (t == 31) chk("sd_pwnd_e31", 32'(camera_pwnd), 32'd0);
            if (t == 32) chk("sd_pwnd_e32", 32'(camera_pwnd), 32'd1);
            if (t == 32) chk("sd_state_e32", 32'(seq_state),  32'd0);
        end

        // Restart pulse in READY with enable held high.
        do_reset();
        for (int t = 0; t <= 55; t++) begin
            tick(1'b0, 1'b1, (t == 30));
            if (t == 30) chk("rs_rstn_e30",  32'(camera_rstn), 32'b00);
            if (t == 32) chk("rs_pwnd_e32",  32'(camera_pwnd), 32'd1);
            if (t == 33) chk("rs_state_e33", 32'(seq_state),   32'd1);
            if (t == 52) chk("rs_ie_e52",    32'(initial_en),  32'd0);
            if (t == 53) chk("rs_ie_e53",    32'(initial_en),  32'd1);
        end

        // Abort in STAGGER after the first release.
        do_reset();
        for (int t = 0; t <= 25; t++) begin
            tick(1'b0, (t < 13), 1'b0);
            if (t == 12) chk("ab_rstn_e12",  32'(camera_rstn), 32'b01);
            if (t == 13) chk("ab_rstn_e13",  32'(camera_rstn), 32'b00);
            if (t == 14) chk("ab_pwnd_e14",  32'(camera_pwnd), 32'd0);
            if (t == 15) chk("ab_pwnd_e15",  32'(camera_pwnd), 32'd1);
            if (t == 15) chk("ab_state_e15", 32'(seq_state),   32'd0);
            if (t == 25) chk("ab_rstn_e25",  32'(camera_rstn), 32'b00);
        end

        // Restart outside READY is ignored.
        do_reset();
        for (int t = 0; t <= 21; t++) begin
            tick(1'b0, 1'b1, (t == 5));
            if (t == 19) chk("ig_ie_e19", 32'(initial_en), 32'd0);
            if (t == 20) chk("ig_ie_e20", 32'(initial_en), 32'd1);
        end

        // Synchronous reset in the middle of STAGGER.
        do_reset();
        for (int t = 0; t <= 17; t++) begin
            tick((t == 15), 1'b1, 1'b0);
            if (t == 14) chk("mr_pwnd_e14",  32'(camera_pwnd), 32'd0);
            if (t == 15) chk("mr_pwnd_e15",  32'(camera_pwnd), 32'd1);
            if (t == 15) chk("mr_rstn_e15",  32'(camera_rstn), 32'b00);
            if (t == 15) chk("mr_state_e15", 32'(seq_state),   32'd0);
        end

        // Random enable/restart/reset traffic.
        do_reset();
        en_r = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 39) == 0) en_r = ~en_r;
            tick(($urandom_range(0, 599) == 0), en_r, ($urandom_range(0, 11) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
